// File: rtl/div_pkg.sv
// Shared types and constants for the sequential radix-2 restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } div_state_t;

    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = $clog2(DIV_W);

    localparam logic [DIV_W-1:0] DIV0_QUOTIENT = '1;

endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negate, used both for operand magnitudes and
// for the final sign fix-up of quotient and remainder.
module div_abs_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg_en,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg_en ? -i_val : i_val;

endmodule

// File: rtl/divider_seq.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned) with level-held enable.
// Define DIV_EARLY_OUT_EN to skip iterations when |dividend| < |divisor|.
module divider_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sign,
    input  logic             enable,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divready,
    output logic             div_by_zero
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    div_state_t       w_nextState;
    logic             r_sign;
    logic             r_dvdNeg;
    logic             r_dsrNeg;
    logic [WIDTH-1:0] r_dsrMag;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH:0]   r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_divready;
    logic             r_divByZero;

    logic [WIDTH-1:0] w_dvdMag;
    logic [WIDTH-1:0] w_dsrMag;
    logic [WIDTH-1:0] w_qFixed;
    logic [WIDTH-1:0] w_remFixed;
    logic [WIDTH:0]   w_remShift;
    logic [WIDTH:0]   w_remDiff;
    logic             w_geq;
    logic             w_divisorZero;
    logic             w_early;

    div_abs_neg #(.W(WIDTH)) u_dvdAbs (
        .i_val    (dividend),
        .i_neg_en (sign & dividend[WIDTH-1]),
        .o_val    (w_dvdMag)
    );

    div_abs_neg #(.W(WIDTH)) u_dsrAbs (
        .i_val    (divisor),
        .i_neg_en (sign & divisor[WIDTH-1]),
        .o_val    (w_dsrMag)
    );

    div_abs_neg #(.W(WIDTH)) u_qFix (
        .i_val    (r_q),
        .i_neg_en (r_sign & (r_dvdNeg ^ r_dsrNeg)),
        .o_val    (w_qFixed)
    );

    div_abs_neg #(.W(WIDTH)) u_remFix (
        .i_val    (r_rem[WIDTH-1:0]),
        .i_neg_en (r_sign & r_dvdNeg),
        .o_val    (w_remFixed)
    );

    assign w_divisorZero = (divisor == '0);
    assign w_remShift    = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_remDiff     = w_remShift - {1'b0, r_dsrMag};
    // A set top bit means the shifted value already exceeds any WIDTH-bit divisor.
    assign w_geq         = r_rem[WIDTH] | (w_remShift >= {1'b0, r_dsrMag});

`ifdef DIV_EARLY_OUT_EN
    assign w_early = !w_divisorZero && (w_dvdMag < w_dsrMag);
`else
    assign w_early = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    if (w_divisorZero)  w_nextState = DONE;
                    else if (w_early)   w_nextState = FIX;
                    else                w_nextState = RUN;
                end
            end
            RUN: begin
                if (!enable)                 w_nextState = IDLE;
                else if (r_cnt == LAST_CNT)  w_nextState = FIX;
            end
            FIX: begin
                w_nextState = enable ? DONE : IDLE;
            end
            DONE: begin
                if (!enable) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Results only ever become visible in FIX or the divide-by-zero load, so an
    // abort from RUN/FIX leaves the outputs at their cleared value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign      <= 1'b0;
            r_dvdNeg    <= 1'b0;
            r_dsrNeg    <= 1'b0;
            r_dsrMag    <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_divready  <= 1'b0;
            r_divByZero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_sign   <= sign;
                        r_dvdNeg <= sign & dividend[WIDTH-1];
                        r_dsrNeg <= sign & divisor[WIDTH-1];
                        r_dsrMag <= w_dsrMag;
                        r_cnt    <= '0;
                        if (w_early) begin
                            r_q   <= '0;
                            r_rem <= {1'b0, w_dvdMag};
                        end else begin
                            r_q   <= w_dvdMag;
                            r_rem <= '0;
                        end
                        if (w_divisorZero) begin
                            r_quotient  <= DIV0_QUOTIENT;
                            r_remainder <= dividend;
                            r_divready  <= 1'b1;
                            r_divByZero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (enable) begin
                        r_q   <= {r_q[WIDTH-2:0], w_geq};
                        r_rem <= w_geq ? w_remDiff : w_remShift;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                FIX: begin
                    if (enable) begin
                        r_quotient  <= w_qFixed;
                        r_remainder <= w_remFixed;
                        r_divready  <= 1'b1;
                    end
                end
                DONE: begin
                    if (!enable) begin
                        r_quotient  <= '0;
                        r_remainder <= '0;
                        r_divready  <= 1'b0;
                        r_divByZero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign divready    = r_divready;
    assign div_by_zero = r_divByZero;

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed cases, randomized operations,
// abort, asynchronous reset and result-hold behaviour against an arithmetic model.
module tb_divider_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sign = 1'b0;
    logic          enable = 1'b0;
    logic [W-1:0]  dividend = '0;
    logic [W-1:0]  divisor = '0;
    logic [W-1:0]  quotient;
    logic [W-1:0]  remainder;
    logic          divready;
    logic          div_by_zero;

    int checks = 0;
    int errors = 0;

    divider_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sign        (sign),
        .enable      (enable),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .divready    (divready),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero
    // and give the remainder the dividend's sign.
    function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output int lat);
        longint sa, sb, qq, rr, ma, mb;
        dz = (b == 0);
        if (b == 0) begin
            q   = '1;
            r   = a;
            lat = 1;
        end else begin
            if (s) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'(a);
                sb = longint'(b);
            end
            qq = sa / sb;
            rr = sa % sb;
            q  = qq[W-1:0];
            r  = rr[W-1:0];
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
            lat = W + 2;
`ifdef DIV_EARLY_OUT_EN
            if (ma < mb) lat = 2;
`endif
        end
    endfunction

    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        logic [W-1:0] eq, er;
        logic         edz;
        int           lat, edges;
        logic         got, stable;
        model(s, a, b, eq, er, edz, lat);
        @(negedge clk);
        sign = s; dividend = a; divisor = b; enable = 1'b1;
        edges = 0; got = 1'b0;
        while (!got && edges < 60) begin
            @(posedge clk); #1;
            edges++;
            if (divready) got = 1'b1;
        end
        checks++;
        if (!got || edges !== lat) begin
            errors++;
            $display("[TB] FAIL %s latency: got %0d edges (ready=%0b) expected %0d", name, edges, got, lat);
        end
        checks++;
        if (quotient !== eq) begin
            errors++;
            $display("[TB] FAIL %s quotient: got %h expected %h", name, quotient, eq);
        end
        checks++;
        if (remainder !== er) begin
            errors++;
            $display("[TB] FAIL %s remainder: got %h expected %h", name, remainder, er);
        end
        checks++;
        if (div_by_zero !== edz) begin
            errors++;
            $display("[TB] FAIL %s div_by_zero: got %0b expected %0b", name, div_by_zero, edz);
        end
        stable = 1'b1;
        repeat (3) begin
            @(negedge clk);
            dividend = $urandom; divisor = $urandom; sign = ~sign;
            @(posedge clk); #1;
            if (divready !== 1'b1 || quotient !== eq || remainder !== er || div_by_zero !== edz) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("[TB] FAIL %s hold: outputs changed while enable held (q=%h r=%h rdy=%0b)", name, quotient, remainder, divready);
        end
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (divready !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s clear: got rdy=%0b q=%h r=%h dz=%0b expected all 0", name, divready, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({divready, div_by_zero, quotient, remainder} !== '0) begin
            errors++;
            $display("[TB] FAIL reset outputs: got rdy=%0b dz=%0b q=%h r=%h expected 0", divready, div_by_zero, quotient, remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({divready, div_by_zero, quotient, remainder} !== '0) begin
            errors++;
            $display("[TB] FAIL idle outputs: got rdy=%0b q=%h r=%h expected 0", divready, quotient, remainder);
        end
    endtask

    task automatic test_directed();
        run_op(1'b0, 32'd7,        32'd2,        "u7div2");
        run_op(1'b1, 32'hFFFFFFF8, 32'd2,        "sneg8div2");
        run_op(1'b1, 32'd8,        32'hFFFFFFFD, "s8divneg3");
        run_op(1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, "sneg7divneg2");
        run_op(1'b0, 32'hFFFFFFF8, 32'd2,        "ubigdiv2");
        run_op(1'b0, 32'd5,        32'd0,        "u5div0");
        run_op(1'b1, 32'd5,        32'd0,        "s5div0");
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, "soverflow");
        run_op(1'b1, 32'd3,        32'hFFFFFFF9, "s3divneg7");
        run_op(1'b0, 32'd0,        32'd9,        "u0div9");
        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, "umaxdivmax");
        run_op(1'b0, 32'h12345678, 32'd1,        "udiv1");
    endtask

    task automatic test_abort();
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        sign = 1'b0; dividend = 32'd100; divisor = 32'd7; enable = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (divready || quotient !== '0 || remainder !== '0) seen = 1'b1;
        end
        @(negedge clk);
        enable = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (divready || quotient !== '0 || remainder !== '0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("[TB] FAIL abort: result exposed after abort (rdy=%0b q=%h) expected none", divready, quotient);
        end
        run_op(1'b0, 32'd100, 32'd7, "restart100div7");
    endtask

    task automatic test_async_reset();
        // Reset while a divide-by-zero result is displayed, between clock edges.
        @(negedge clk);
        sign = 1'b0; dividend = 32'd5; divisor = 32'd0; enable = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (divready !== 1'b0 || div_by_zero !== 1'b0 || quotient !== '0 || remainder !== '0) begin
            errors++;
            $display("[TB] FAIL async reset in DONE: got rdy=%0b dz=%0b q=%h r=%h expected 0", divready, div_by_zero, quotient, remainder);
        end
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sign = 1'b0; dividend = 32'd9; divisor = 32'd3; enable = 1'b1;
        repeat (10) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({divready, div_by_zero, quotient, remainder} !== '0) begin
            errors++;
            $display("[TB] FAIL reset mid-run: got rdy=%0b q=%h r=%h expected 0", divready, quotient, remainder);
        end
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 32'd9, 32'd3, "after_reset9div3");
    endtask

    task automatic test_random();
        logic         s;
        logic [W-1:0] a, b;
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = $urandom_range(1, 15);
                2:       b = -$urandom_range(1, 15);
                default: b = a >> $urandom_range(0, 31);
            endcase
            run_op(s, a, b, $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_back_to_back();
        run_op(1'b1, 32'hFFFFFF9C, 32'd7,        "b2b_a");
        run_op(1'b1, 32'd100,      32'hFFFFFFF9, "b2b_b");
        run_op(1'b0, 32'd1,        32'd0,        "b2b_c");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_async_reset();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
